wb_regfile: RTL and testbench

- Writeback stage plus architectural register file. It consumes the MEM/WB pipeline register outputs: write-data select, write enable, npc, ALU result, DM read data and destination number.
- It selects the writeback value and commits it to a 32-entry register file on the rising edge.
- It serves two asynchronous read ports to the ID stage.
- It also keeps a retired-write counter for debug and performance.

---
 rtl/wb_regfile.sv | 74 +++++++
 tb/tb_wb_regfile.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback select, 32-entry register file with two async read ports, retired-write counter.
// Define WB_BYPASS_EN to forward the writeback value to a matching read port in the same cycle.
module wb_regfile #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REG_NUM_WIDTH = 5,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               s_data_write_in,
  input  logic                     reg_write_in,
  input  logic [DATA_WIDTH-1:0]    npc_in,
  input  logic [DATA_WIDTH-1:0]    alu_res_in,
  input  logic [DATA_WIDTH-1:0]    dm_read_in,
  input  logic [REG_NUM_WIDTH-1:0] num_write_in,
  input  logic [REG_NUM_WIDTH-1:0] num_read1_in,
  input  logic [REG_NUM_WIDTH-1:0] num_read2_in,
  output logic [DATA_WIDTH-1:0]    data_read1_out,
  output logic [DATA_WIDTH-1:0]    data_read2_out,
  output logic [DATA_WIDTH-1:0]    wb_data_out,
  output logic                     wb_valid_out,
  output logic [CNT_WIDTH-1:0]     retire_cnt_out
);

  localparam int unsigned NREGS = 2 ** REG_NUM_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic                  commit;

  always_comb begin
    unique case (s_data_write_in)
      2'b01:   wb_data_out = dm_read_in;
      2'b10:   wb_data_out = npc_in;
      default: wb_data_out = alu_res_in;
    endcase
  end

  assign commit = reg_write_in && (num_write_in != '0);

  // Entry 0 is cleared on reset and never written, so it stays zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      wb_valid_out   <= 1'b0;
      retire_cnt_out <= '0;
    end else begin
      if (commit) regs[num_write_in] <= wb_data_out;
      wb_valid_out <= commit;
      if (reg_write_in) retire_cnt_out <= retire_cnt_out + CNT_WIDTH'(1);
    end
  end

`ifdef WB_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = commit && !reset;

  always_comb begin
    data_read1_out = regs[num_read1_in];
    data_read2_out = regs[num_read2_in];
    if (fwd_ok && (num_read1_in == num_write_in)) data_read1_out = wb_data_out;
    if (fwd_ok && (num_read2_in == num_write_in)) data_read2_out = wb_data_out;
    if (num_read1_in == '0) data_read1_out = '0;
    if (num_read2_in == '0) data_read2_out = '0;
  end
`else
  always_comb begin
    data_read1_out = regs[num_read1_in];
    data_read2_out = regs[num_read2_in];
    if (num_read1_in == '0) data_read1_out = '0;
    if (num_read2_in == '0) data_read2_out = '0;
  end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: table-driven mux vectors, directed corner sequences,
// and randomized traffic against a behavioural register-file model (4-bit counter instance).
module tb_wb_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    s_data_write_in;
  logic          reg_write_in;
  logic [DW-1:0] npc_in, alu_res_in, dm_read_in;
  logic [RW-1:0] num_write_in, num_read1_in, num_read2_in;
  logic [DW-1:0] data_read1_out, data_read2_out, wb_data_out;
  logic          wb_valid_out;
  logic [CW-1:0] retire_cnt_out;

  wb_regfile #(.DATA_WIDTH(DW), .REG_NUM_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .s_data_write_in(s_data_write_in),
    .reg_write_in(reg_write_in), .npc_in(npc_in), .alu_res_in(alu_res_in),
    .dm_read_in(dm_read_in), .num_write_in(num_write_in),
    .num_read1_in(num_read1_in), .num_read2_in(num_read2_in),
    .data_read1_out(data_read1_out), .data_read2_out(data_read2_out),
    .wb_data_out(wb_data_out), .wb_valid_out(wb_valid_out),
    .retire_cnt_out(retire_cnt_out)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [DW-1:0] m_regs [32];
  int unsigned   m_cnt   = 0;
  logic          m_valid = 1'b0;

  typedef struct {
    logic [1:0]    sel;
    logic [RW-1:0] wn;
    logic [DW-1:0] exp;
  } mux_vec_t;

  mux_vec_t mv [4];

  function automatic logic [DW-1:0] m_wb();
    case (s_data_write_in)
      2'b01:   return dm_read_in;
      2'b10:   return npc_in;
      default: return alu_res_in;
    endcase
  endfunction

  function automatic logic [DW-1:0] m_read(logic [RW-1:0] idx);
    if (idx == 0) return '0;
`ifdef WB_BYPASS_EN
    if (!reset && reg_write_in && num_write_in != 0 && idx == num_write_in) return m_wb();
`endif
    return m_regs[idx];
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_wb"},  wb_data_out, m_wb());
    chk({tag, "_rd1"}, data_read1_out, m_read(num_read1_in));
    chk({tag, "_rd2"}, data_read2_out, m_read(num_read2_in));
    chk({tag, "_valid"}, DW'(wb_valid_out), DW'(m_valid));
    chk({tag, "_cnt"}, DW'(retire_cnt_out), DW'(m_cnt));
  endtask

  // Advance one edge and apply the architectural rules to the model.
  task automatic tick();
    logic [DW-1:0] wb;
    @(posedge clock);
    wb = m_wb();
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt   = 0;
      m_valid = 1'b0;
    end else begin
      m_valid = reg_write_in && (num_write_in != 0);
      if (m_valid) m_regs[num_write_in] = wb;
      if (reg_write_in) m_cnt = (m_cnt + 1) % (1 << CW);
    end
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic we, input logic [RW-1:0] wn,
                       input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                       input logic [DW-1:0] alu, input logic [DW-1:0] dm, input logic [DW-1:0] npc);
    s_data_write_in = sel;
    reg_write_in    = we;
    num_write_in    = wn;
    num_read1_in    = r1;
    num_read2_in    = r2;
    alu_res_in      = alu;
    dm_read_in      = dm;
    npc_in          = npc;
    #3;
  endtask

  initial begin
    mv[0] = '{sel: 2'b00, wn: 5'd5, exp: 32'h1111_1111};
    mv[1] = '{sel: 2'b01, wn: 5'd6, exp: 32'h2222_2222};
    mv[2] = '{sel: 2'b10, wn: 5'd7, exp: 32'h3333_3333};
    mv[3] = '{sel: 2'b11, wn: 5'd8, exp: 32'h1111_1111};

    // Reset, then sweep every index on both ports.
    reset = 1'b1;
    drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(2'b00, 1'b0, 5'd0, 5'(i), 5'(31 - i), '0, '0, '0);
      chk("rst_rd1", data_read1_out, 32'h0);
      chk("rst_rd2", data_read2_out, 32'h0);
      if (i == 0) begin
        chk("rst_cnt", DW'(retire_cnt_out), 32'd0);
        chk("rst_valid", DW'(wb_valid_out), 32'd0);
      end
      tick();
    end

    // Writeback mux select table.
    for (int i = 0; i < 4; i++) begin
      drive(mv[i].sel, 1'b1, mv[i].wn, 5'd0, 5'd0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
      chk("mux_wb", wb_data_out, mv[i].exp);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 1'b0, 5'd0, mv[i].wn, mv[i].wn, '0, '0, '0);
      chk("mux_rd1", data_read1_out, mv[i].exp);
      chk("mux_rd2", data_read2_out, mv[i].exp);
    end
    chk("mux_cnt", DW'(retire_cnt_out), 32'd4);

    // $0 protection: write discarded, but it still counts.
    drive(2'b00, 1'b1, 5'd0, 5'd0, 5'd0, 32'hDEAD_BEEF, '0, '0);
    chk("r0_rd_pre", data_read1_out, 32'h0);
    tick();
    drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0);
    chk("r0_rd", data_read1_out, 32'h0);
    chk("r0_valid", DW'(wb_valid_out), 32'd0);
    chk("r0_cnt", DW'(retire_cnt_out), 32'd5);

    // Same-edge write and read of $9.
    drive(2'b00, 1'b1, 5'd9, 5'd0, 5'd0, 32'hAAAA_0000, '0, '0);
    tick();
    drive(2'b00, 1'b1, 5'd9, 5'd9, 5'd9, 32'h0000_BBBB, '0, '0);
`ifdef WB_BYPASS_EN
    chk("same_pre", data_read1_out, 32'h0000_BBBB);
`else
    chk("same_pre", data_read1_out, 32'hAAAA_0000);
`endif
    tick();
    drive(2'b00, 1'b0, 5'd0, 5'd9, 5'd0, '0, '0, '0);
    chk("same_post", data_read1_out, 32'h0000_BBBB);
    chk("same_valid", DW'(wb_valid_out), 32'd1);
    chk("same_cnt", DW'(retire_cnt_out), 32'd7);

    // Reset wins over a simultaneous write; next write after reset commits.
    reset = 1'b1;
    drive(2'b00, 1'b1, 5'd3, 5'd3, 5'd9, 32'h1234_5678, '0, '0);
    chk("rstpri_rd_pre", data_read1_out, 32'h0);
    tick();
    reset = 1'b0;
    drive(2'b00, 1'b0, 5'd0, 5'd3, 5'd9, '0, '0, '0);
    chk("rstpri_rd3", data_read1_out, 32'h0);
    chk("rstpri_rd9", data_read2_out, 32'h0);
    chk("rstpri_cnt", DW'(retire_cnt_out), 32'd0);
    chk("rstpri_valid", DW'(wb_valid_out), 32'd0);
    drive(2'b00, 1'b1, 5'd3, 5'd0, 5'd0, 32'h1234_5678, '0, '0);
    tick();
    drive(2'b00, 1'b0, 5'd0, 5'd3, 5'd0, '0, '0, '0);
    chk("postrst_rd3", data_read1_out, 32'h1234_5678);
    chk("postrst_cnt", DW'(retire_cnt_out), 32'd1);

    // Counter wrap at 4 bits: 17 writes from zero leaves 1.
    reset = 1'b1;
    drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 17; k++) begin
      drive(2'b00, 1'b1, 5'd10, 5'd0, 5'd0, DW'(k), '0, '0);
      tick();
      if (k == 14) chk("wrap_ones", DW'(retire_cnt_out), 32'd15);
      if (k == 15) chk("wrap_zero", DW'(retire_cnt_out), 32'd0);
    end
    drive(2'b00, 1'b0, 5'd0, 5'd10, 5'd0, '0, '0, '0);
    chk("wrap_cnt", DW'(retire_cnt_out), 32'd1);
    chk("wrap_rd10", data_read1_out, 32'd16);

    // Randomized traffic against the model, with read indices biased toward the write target.
    for (int n = 0; n < 400; n++) begin
      logic [RW-1:0] wn, r1, r2;
      reset = ($urandom_range(0, 24) == 0);
      wn = RW'($urandom_range(0, 31));
      if (n % 7 == 0) wn = '0;
      r1 = ($urandom_range(0, 1) == 1) ? wn : RW'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? wn : RW'($urandom_range(0, 31));
      drive(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), wn, r1, r2,
            $urandom, $urandom, $urandom);
      check_all("rand");
      tick();
    end
    reset = 1'b0;
    drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0);
    check_all("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
